gpio_input_capture: RTL

- Input-direction companion to the GPIO byte: samples the 8 pad inputs (gpio_data_in from the GPIO byte), synchronises and debounces them, and detects rising/falling edges.
- Edges are latched as sticky events, which the Picoblaze reads back and clears with write-1-to-clear.
- Raises a Picoblaze-style interrupt that is held until interrupt_ack.
- Sits between the GPIO byte and the CPU port-mapped register decode.

---
 rtl/gpio_input_capture_pkg.sv | 28 ++
 rtl/gpio_input_capture_if.sv | 36 +++
 rtl/gpio_debounce_bit.sv | 63 ++++++
 rtl/gpio_input_capture.sv | 76 +++++++
 4 files changed

// File: rtl/gpio_input_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_capture_pkg
// Description : Constants, types and helpers shared by the GPIO byte, the
//               input-capture block and the CPU register decode.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_input_capture_pkg;

    localparam int GPIO_WIDTH              = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;

    // Edge events for the bits whose stable level is about to flip. The new
    // level is the inverse of the current one, so a rising edge is a bit that
    // is currently low and a falling edge is a bit that is currently high.
    function automatic gpio_vec_t edge_set(
        input gpio_vec_t upd,
        input gpio_vec_t level_now,
        input gpio_vec_t rise_en,
        input gpio_vec_t fall_en
    );
        return upd & ((~level_now & rise_en) | (level_now & fall_en));
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_input_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_capture_if
// Description : CPU-side register bus of the GPIO input-capture block.
//               master : register decode (drives enables, masks, clear, ack)
//               slave  : capture block (drives level, status, interrupt)
// Signals     : rise_en, fall_en, irq_mask, clear_strobe, clear_mask,
//               interrupt_ack (master->slave);
//               gpio_level, event_status, interrupt (slave->master)
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_input_capture_if;
    import gpio_input_capture_pkg::*;

    gpio_vec_t rise_en;
    gpio_vec_t fall_en;
    gpio_vec_t irq_mask;
    logic      clear_strobe;
    gpio_vec_t clear_mask;
    logic      interrupt_ack;
    gpio_vec_t gpio_level;
    gpio_vec_t event_status;
    logic      interrupt;

    modport master (
        output rise_en, fall_en, irq_mask, clear_strobe, clear_mask, interrupt_ack,
        input  gpio_level, event_status, interrupt
    );

    modport slave (
        input  rise_en, fall_en, irq_mask, clear_strobe, clear_mask, interrupt_ack,
        output gpio_level, event_status, interrupt
    );

endinterface
`default_nettype wire

// File: rtl/gpio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce_bit
// Description : Single-bit 2-flop synchroniser followed by a debounce counter
//               and stable-level flop. The level follows the synchronised pin
//               only after it has differed for DEBOUNCE_CYCLES edges in a row.
// Ports       : clk, reset (sync, active-high)
//               pin   - raw asynchronous pad input
//               level - debounced stable level
//               upd   - high in the cycle whose edge flips level
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic pin,
    output logic      level,
    output logic      upd
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_upd;

    assign w_differs = (r_s2 != r_level);
    assign w_upd     = w_differs && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= INIT_LEVEL;
            r_s2    <= INIT_LEVEL;
            r_level <= INIT_LEVEL;
            r_cnt   <= '0;
        end else begin
            r_s1 <= pin;
            r_s2 <= r_s1;
            // Any cycle agreeing with the stable level restarts the count,
            // so a glitch shorter than the window leaves no residue.
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_upd) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign upd   = w_upd;

endmodule
`default_nettype wire

// File: rtl/gpio_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : gpio_input_capture
// Description : Synchronises and debounces the GPIO pad inputs, latches
//               enabled rising/falling edges as sticky write-1-to-clear
//               events and raises an interrupt held until acknowledged.
// Ports       : clk, reset (sync, active-high)
//               gpio_in - raw asynchronous pad inputs
//               bus     - CPU register interface (slave modport):
//                         rise_en/fall_en/irq_mask, clear_strobe/clear_mask,
//                         interrupt_ack in; gpio_level/event_status/interrupt out
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_input_capture
    import gpio_input_capture_pkg::*;
#(
    parameter int        DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter gpio_vec_t INIT_LEVEL      = 8'h00
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire gpio_vec_t      gpio_in,
    gpio_input_capture_if.slave bus
);

    gpio_vec_t w_level;
    gpio_vec_t w_upd;
    gpio_vec_t w_set;
    gpio_vec_t w_status_next;
    logic      w_new_irq;
    gpio_vec_t r_event_status;
    logic      r_interrupt;

    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_LEVEL      (INIT_LEVEL[gi])
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .pin   (gpio_in[gi]),
            .level (w_level[gi]),
            .upd   (w_upd[gi])
        );
    end

    always_comb begin
        w_set         = edge_set(w_upd, w_level, bus.rise_en, bus.fall_en);
        // OR-ing the set vector last makes a new event win over a clear of
        // the same bit in the same cycle.
        w_status_next = (bus.clear_strobe ? (r_event_status & ~bus.clear_mask)
                                          : r_event_status) | w_set;
        // Only fresh events interrupt; pending status bits never re-raise it.
        w_new_irq     = |(w_set & bus.irq_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_event_status <= '0;
            r_interrupt    <= 1'b0;
        end else begin
            r_event_status <= w_status_next;
            if (w_new_irq) begin
                r_interrupt <= 1'b1;
            end else if (bus.interrupt_ack) begin
                r_interrupt <= 1'b0;
            end
        end
    end

    assign bus.gpio_level   = w_level;
    assign bus.event_status = r_event_status;
    assign bus.interrupt    = r_interrupt;

endmodule
`default_nettype wire
